// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of one UART TX byte port.
// R frame sources compete; the winner streams a full N-byte frame
// through o_sel before the grant passes on.
// Ports:
//   clk, rst            clock, async active-high reset
//   i_req[R]            frame request per source
//   i_data[R*8]         current byte of each source (indexed by o_sel)
//   o_grant[R]          registered one-hot owner, 0 when idle
//   o_sel[SW]           byte index within the granted frame
//   o_done[R]           1-cycle pulse on the finished source
//   o_busy              high while a frame is being sent or closed
//   o_tx_data/valid     byte toward the UART
//   i_tx_ready          UART accepts the byte
//   o_abort             1-cycle pulse on stall timeout
// Optional: define UART_ARB_TIMEOUT_EN to enable the stall timeout.
module uart_tx_arbiter #(
    parameter  int R       = 4,
    parameter  int N       = 16,
    parameter  int TIMEOUT = 255,
    localparam int SW      = $clog2(N),
    localparam int PW      = $clog2(R)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    i_req,
    input  logic [R*8-1:0]  i_data,
    output logic [R-1:0]    o_grant,
    output logic [SW-1:0]   o_sel,
    output logic [R-1:0]    o_done,
    output logic            o_busy,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_valid,
    input  logic            i_tx_ready,
    output logic            o_abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [R-1:0]    grant, grant_nx;
    logic [SW-1:0]   sel, sel_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [PW-1:0]   gidx, gidx_nx;
    logic [PW-1:0]   ptr_adv;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   pick;
    logic            found;
    logic            xfer;
    logic [7:0]      tx_byte;

`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0]      stall, stall_nx;
    logic            abort_q, abort_nx;
`endif

    // Search order starts at ptr and wraps, so the last owner goes last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < R; i++) begin
            idx = PW'((int'(ptr) + i) % R);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign ptr_adv = (gidx == PW'(R - 1)) ? '0 : gidx + PW'(1);
    assign xfer    = o_tx_valid & i_tx_ready;

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        sel_nx   = sel;
        ptr_nx   = ptr;
        gidx_nx  = gidx;
`ifdef UART_ARB_TIMEOUT_EN
        stall_nx = stall;
        abort_nx = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_nx       = '0;
                    grant_nx[pick] = 1'b1;
                    gidx_nx        = pick;
                    sel_nx         = '0;
                    state_nx       = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    stall_nx       = '0;
`endif
                end
            end
            SEND: begin
                if (xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
                    stall_nx = '0;
`endif
                    if (sel == SW'(N - 1)) begin
                        state_nx = DONE;
                    end else begin
                        sel_nx = sel + SW'(1);
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (stall == 8'(TIMEOUT - 1)) begin
                    // Frame dropped: hand the port on, no done.
                    abort_nx = 1'b1;
                    stall_nx = '0;
                    grant_nx = '0;
                    sel_nx   = '0;
                    ptr_nx   = ptr_adv;
                    state_nx = IDLE;
                end else begin
                    stall_nx = stall + 8'd1;
                end
`endif
            end
            DONE: begin
                grant_nx = '0;
                sel_nx   = '0;
                ptr_nx   = ptr_adv;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                sel_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= '0;
            gidx  <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
            gidx  <= gidx_nx;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall   <= '0;
            abort_q <= 1'b0;
        end else begin
            stall   <= stall_nx;
            abort_q <= abort_nx;
        end
    end

    assign o_abort = abort_q;
`else
    assign o_abort = 1'b0;
`endif

    always_comb begin
        tx_byte = '0;
        for (int r = 0; r < R; r++) begin
            if (grant[r]) begin
                tx_byte = i_data[8*r +: 8];
            end
        end
    end

    assign o_grant    = grant;
    assign o_sel      = sel;
    assign o_tx_valid = (state == SEND);
    assign o_done     = (state == DONE) ? grant : '0;
    assign o_busy     = (state != IDLE);
    assign o_tx_data  = o_tx_valid ? tx_byte : '0;

endmodule
